// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : conv_pkg
//  Brief   : Shared constants, one-hot state codes and helpers for the
//            1-D convolution sequencer.
//  Revision: 1.0  initial release
// ============================================================================
package conv_pkg;

  localparam int c_addr_w_def  = 5;
  localparam int c_zaddr_w_def = 6;

  localparam int c_st_w = 7;
  localparam logic [c_st_w-1:0] c_st_idle  = 7'b000_0001;
  localparam logic [c_st_w-1:0] c_st_init  = 7'b000_0010;
  localparam logic [c_st_w-1:0] c_st_setup = 7'b000_0100;
  localparam logic [c_st_w-1:0] c_st_read  = 7'b000_1000;
  localparam logic [c_st_w-1:0] c_st_drain = 7'b001_0000;
  localparam logic [c_st_w-1:0] c_st_write = 7'b010_0000;
  localparam logic [c_st_w-1:0] c_st_done  = 7'b100_0000;

  // Number of products contributing to one output sample.
  function automatic int unsigned term_count(input int unsigned j_lo, input int unsigned j_hi);
    return j_hi - j_lo + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : conv_seq_ctrl_if
//  Brief   : Host/datapath-facing signal bundle of the convolution sequencer.
//  Revision: 1.0  initial release
// ============================================================================
interface conv_seq_ctrl_if
  import conv_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_def,
  parameter int ZADDR_W = c_zaddr_w_def
);

  logic               start_i;
  logic [ADDR_W:0]    size_x_i;
  logic [ADDR_W:0]    size_y_i;
  logic               busy_o;
  logic               done_o;
  logic               err_o;
  logic               rd_en_o;
  logic [ADDR_W-1:0]  x_addr_o;
  logic [ADDR_W-1:0]  y_addr_o;
  logic               mac_clr_o;
  logic               mac_en_o;
  logic               z_we_o;
  logic [ZADDR_W-1:0] z_addr_o;

  modport master (
    output start_i, size_x_i, size_y_i,
    input  busy_o, done_o, err_o, rd_en_o, x_addr_o, y_addr_o,
    input  mac_clr_o, mac_en_o, z_we_o, z_addr_o
  );

  modport slave (
    input  start_i, size_x_i, size_y_i,
    output busy_o, done_o, err_o, rd_en_o, x_addr_o, y_addr_o,
    output mac_clr_o, mac_en_o, z_we_o, z_addr_o
  );

endinterface
`default_nettype wire

// File: rtl/conv_bounds.sv
`default_nettype none
// ============================================================================
//  Module  : conv_bounds
//  Brief   : Combinational j range for output index i:
//            j_lo = max(0, i-(Ny-1)), j_hi = min(i, Nx-1).
//  Revision: 1.0  initial release
// ============================================================================
module conv_bounds
  import conv_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_def,
  parameter int ZADDR_W = c_zaddr_w_def
) (
  input  wire logic [ZADDR_W-1:0] i,
  input  wire logic [ADDR_W:0]    nx,
  input  wire logic [ADDR_W:0]    ny,
  output logic      [ADDR_W-1:0]  j_lo,
  output logic      [ADDR_W-1:0]  j_hi
);

  localparam int c_w = ZADDR_W + 1;

  logic [c_w-1:0] w_i;
  logic [c_w-1:0] w_nx;
  logic [c_w-1:0] w_ny_m1;
  logic [c_w-1:0] w_lo;
  logic [c_w-1:0] w_hi;
  logic           w_unused_hi;

  assign w_i     = {1'b0, i};
  assign w_nx    = {{(c_w-ADDR_W-1){1'b0}}, nx};
  assign w_ny_m1 = {{(c_w-ADDR_W-1){1'b0}}, ny} - c_w'(1);

  assign w_lo = (w_i >= w_ny_m1) ? (w_i - w_ny_m1) : '0;
  assign w_hi = (w_i < w_nx) ? w_i : (w_nx - c_w'(1));

  // Both bounds are below Nx <= 2**ADDR_W for legal sizes, so upper bits are zero.
  assign j_lo        = w_lo[ADDR_W-1:0];
  assign j_hi        = w_hi[ADDR_W-1:0];
  assign w_unused_hi = ^{w_lo[c_w-1:ADDR_W], w_hi[c_w-1:ADDR_W]};

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : conv_seq_ctrl
//  Brief   : Sequencer for Z[i] = sum_j X[j]*Y[i-j]; drives X/Y reads, MAC
//            clear/enable and Z writes, and reports busy/done/err.
//  Revision: 1.0  initial release
// ============================================================================
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_def,
  parameter int ZADDR_W = c_zaddr_w_def
) (
  input  wire logic       clk,
  input  wire logic       rstn,
  conv_seq_ctrl_if.slave  bus
);

  localparam int               c_w        = ZADDR_W + 1;
  localparam logic [ADDR_W:0]  c_max_size = {1'b1, {ADDR_W{1'b0}}};

  logic [c_st_w-1:0]  r_state;
  logic [c_st_w-1:0]  w_state_nxt;
  logic [ADDR_W:0]    r_nx;
  logic [ADDR_W:0]    r_ny;
  logic [ZADDR_W-1:0] r_i;
  logic [ADDR_W-1:0]  r_j;
  logic [ADDR_W-1:0]  r_j_hi;
  logic [ADDR_W-1:0]  r_y;
  logic               r_err;
  logic               r_busy, r_done, r_rd, r_clr, r_mac_en, r_we;
  logic               w_busy, w_done, w_rd, w_clr, w_we;
  logic [ADDR_W-1:0]  w_j_lo;
  logic [ADDR_W-1:0]  w_j_hi;
  logic [c_w-1:0]     w_nz_m1;
  logic [c_w-1:0]     w_y_lo;
  logic               w_bad;
  logic               w_last_i;
  logic               w_unused_y;

  conv_bounds #(
    .ADDR_W  (ADDR_W),
    .ZADDR_W (ZADDR_W)
  ) u_bounds (
    .i    (r_i),
    .nx   (r_nx),
    .ny   (r_ny),
    .j_lo (w_j_lo),
    .j_hi (w_j_hi)
  );

  assign w_bad      = (r_nx == '0) || (r_ny == '0) || (r_nx > c_max_size) || (r_ny > c_max_size);
  assign w_nz_m1    = {{(c_w-ADDR_W-1){1'b0}}, r_nx} + {{(c_w-ADDR_W-1){1'b0}}, r_ny} - c_w'(2);
  assign w_last_i   = ({1'b0, r_i} == w_nz_m1);
  assign w_y_lo     = {1'b0, r_i} - {{(c_w-ADDR_W){1'b0}}, w_j_lo};
  assign w_unused_y = ^w_y_lo[c_w-1:ADDR_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // A bad size is first latched into err_o; DONE is taken from the flag on the
  // following cycle so err_o is already stable when done_o pulses.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (bus.start_i) w_state_nxt = c_st_init;
      c_st_init:  begin
        if (r_err)      w_state_nxt = c_st_done;
        else if (w_bad) w_state_nxt = c_st_init;
        else            w_state_nxt = c_st_setup;
      end
      c_st_setup: w_state_nxt = c_st_read;
      c_st_read:  if (r_j == r_j_hi) w_state_nxt = c_st_drain;
      c_st_drain: w_state_nxt = c_st_write;
      c_st_write: w_state_nxt = w_last_i ? c_st_done : c_st_setup;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_rd   = 1'b0;
    w_clr  = 1'b0;
    w_we   = 1'b0;
    w_busy = (w_state_nxt != c_st_idle) && (w_state_nxt != c_st_done);
    w_done = (w_state_nxt == c_st_done);
    w_rd   = (w_state_nxt == c_st_read);
    w_clr  = (w_state_nxt == c_st_setup);
    w_we   = (w_state_nxt == c_st_write);
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd     <= 1'b0;
      r_clr    <= 1'b0;
      r_mac_en <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_rd     <= w_rd;
      r_clr    <= w_clr;
      r_mac_en <= r_rd;
      r_we     <= w_we;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_nx   <= '0;
      r_ny   <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_j_hi <= '0;
      r_y    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.start_i) begin
            r_nx  <= bus.size_x_i;
            r_ny  <= bus.size_y_i;
            r_err <= 1'b0;
          end
        end
        c_st_init: begin
          r_i <= '0;
          if (!r_err && w_bad) r_err <= 1'b1;
        end
        c_st_setup: begin
          r_j    <= w_j_lo;
          r_j_hi <= w_j_hi;
          r_y    <= w_y_lo[ADDR_W-1:0];
        end
        c_st_read: begin
          if (r_j != r_j_hi) begin
            r_j <= r_j + ADDR_W'(1);
            r_y <= r_y - ADDR_W'(1);
          end
        end
        c_st_write: begin
          if (!w_last_i) r_i <= r_i + ZADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.err_o     = r_err;
  assign bus.rd_en_o   = r_rd;
  assign bus.x_addr_o  = r_j;
  assign bus.y_addr_o  = r_y;
  assign bus.mac_clr_o = r_clr;
  assign bus.mac_en_o  = r_mac_en;
  assign bus.z_we_o    = r_we;
  assign bus.z_addr_o  = r_i;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_conv_seq_ctrl
//  Brief   : Self-checking bench for conv_seq_ctrl against a reference list
//            of expected (i, j, i-j) terms and Z writes.
//  Revision: 1.0  initial release
// ============================================================================
module tb_conv_seq_ctrl;

  localparam int ADDR_W  = 5;
  localparam int ZADDR_W = 6;
  localparam int MAX_N   = 1 << ADDR_W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  conv_seq_ctrl_if #(.ADDR_W(ADDR_W), .ZADDR_W(ZADDR_W)) bus ();

  conv_seq_ctrl #(
    .ADDR_W  (ADDR_W),
    .ZADDR_W (ZADDR_W)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {9'd0, bus.busy_o, bus.done_o, bus.err_o, bus.rd_en_o, bus.x_addr_o,
            bus.y_addr_o, bus.mac_clr_o, bus.mac_en_o, bus.z_we_o, bus.z_addr_o};
  endfunction

  // One full run: the model lists every (i, j, i-j) product in order, the
  // expected Z writes 0..Nz-1 and the done edge counted from the accept edge.
  task automatic run_case(input int nx, input int ny, input bit hold);
    int  exp_rd[$];
    int  got_rd[$];
    int  got_z[$];
    bit  legal;
    int  nz, exp_done, done_k, cur_i, rd_seg, en_seg, viol, n_en, n_clr, busy_bad, f;
    bit  prev_rd;
    legal    = (nx >= 1) && (ny >= 1) && (nx <= MAX_N) && (ny <= MAX_N);
    nz       = legal ? nx + ny - 1 : 0;
    exp_done = legal ? 1 + nx * ny + 3 * nz : 2;
    for (int i = 0; i < nz; i++)
      for (int j = 0; j < nx; j++)
        if ((i - j >= 0) && (i - j < ny)) exp_rd.push_back((i << 16) | (j << 8) | (i - j));

    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.size_x_i = (ADDR_W+1)'(nx);
    bus.size_y_i = (ADDR_W+1)'(ny);
    @(posedge clk); #2;
    check_val("busy_on_accept", bus.busy_o, 1);
    check_val("err_clear_on_accept", bus.err_o, 0);
    if (!hold) bus.start_i = 1'b0;

    done_k = -1; cur_i = 0; rd_seg = 0; en_seg = 0; viol = 0;
    n_en = 0; n_clr = 0; busy_bad = 0;
    prev_rd = bus.rd_en_o;
    for (int k = 1; k <= exp_done + 40; k++) begin
      @(posedge clk); #2;
      if (bus.mac_en_o !== prev_rd) viol++;
      if (bus.mac_en_o && bus.mac_clr_o) viol++;
      if (bus.mac_clr_o) begin rd_seg = 0; en_seg = 0; n_clr++; end
      if (bus.mac_en_o) begin en_seg++; n_en++; end
      if (bus.rd_en_o) begin
        got_rd.push_back((cur_i << 16) | (int'(bus.x_addr_o) << 8) | int'(bus.y_addr_o));
        rd_seg++;
      end
      if (bus.z_we_o) begin
        if ((en_seg != rd_seg) || (rd_seg == 0)) viol++;
        got_z.push_back(int'(bus.z_addr_o));
        cur_i++;
      end
      prev_rd = bus.rd_en_o;
      if (bus.done_o) begin done_k = k; break; end
      if (!bus.busy_o) busy_bad++;
    end

    check_val("done_edge", done_k, exp_done);
    check_val("err_at_done", bus.err_o, legal ? 0 : 1);
    check_val("busy_at_done", bus.busy_o, 0);
    check_val("busy_during_run", busy_bad, 0);
    check_val("mac_protocol", viol, 0);
    check_val("n_reads", got_rd.size(), exp_rd.size());
    check_val("n_mac_en", n_en, legal ? nx * ny : 0);
    check_val("n_mac_clr", n_clr, nz);
    check_val("n_writes", got_z.size(), nz);
    for (int r = 0; r < exp_rd.size() && r < got_rd.size(); r++) begin
      f = n_fail;
      check_val($sformatf("read[%0d] i/x/y", r), got_rd[r], exp_rd[r]);
      if (n_fail != f) break;
    end
    for (int r = 0; r < got_z.size(); r++) begin
      f = n_fail;
      check_val($sformatf("z_addr[%0d]", r), got_z[r], r);
      if (n_fail != f) break;
    end

    @(posedge clk); #2;
    check_val("done_one_cycle", bus.done_o, 0);
    if (hold) begin
      check_val("no_restart_from_done", bus.busy_o, 0);
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk);
      #2 check_val("idle_after_hold", bus.busy_o, 0);
    end
  endtask

  initial begin
    int seen;
    bit done_seen;
    bus.start_i  = 1'b0;
    bus.size_x_i = '0;
    bus.size_y_i = '0;
    repeat (3) @(posedge clk);
    #2 check_val("reset_outputs", outs_vec(), 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #2 check_val("idle_outputs", outs_vec(), 0);

    run_case(1, 1, 1'b0);
    run_case(4, 3, 1'b0);
    run_case(1, 32, 1'b0);
    run_case(0, 3, 1'b0);
    repeat (3) @(posedge clk);
    #2 check_val("err_sticky", bus.err_o, 1);
    run_case(4, 3, 1'b1);
    run_case(40, 5, 1'b0);
    run_case(32, 33, 1'b0);
    run_case(32, 32, 1'b0);

    // Reset in the middle of the second i's READ phase of a 4x3 run.
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.size_x_i = (ADDR_W+1)'(4);
    bus.size_y_i = (ADDR_W+1)'(3);
    @(posedge clk); #2 bus.start_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && seen < 2; k++) begin
      @(posedge clk); #2;
      if (bus.rd_en_o) seen++;
    end
    check_val("reached_read", seen, 2);
    #1 rstn = 1'b0;
    #1 check_val("async_reset_outputs", outs_vec(), 0);
    done_seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #2;
      if (bus.done_o) done_seen = 1'b1;
    end
    check_val("no_done_in_reset", done_seen, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #2 check_val("idle_after_release", outs_vec(), 0);
    run_case(4, 3, 1'b0);

    repeat (6) run_case($urandom_range(1, MAX_N), $urandom_range(1, MAX_N), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
